store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//   In-order FIFO of pending stores that sits directly upstream of the
//   2-read/1-write memory and drives its write port (port 0).
//   - Lets the pipeline retire a store in one cycle while the memory port
//     is occupied.
//   - Drains entries to memory oldest-first.
//   - Forwards buffered data to loads that hit a pending address.
// PARAMETERS
//   WIDTH  32  data word width; equals the memory WIDTH
//   DEPTH  4   number of entries; power of two, >= 2
//   AW     10  low address bits compared for forwarding; equals LOG2 of memory WORD
// PORTS
//   clk       in   1      clock; all state updates on posedge
//   rst       in   1      asynchronous, active-low reset (0 = in reset)
//   st_valid  in   1      store request
//   st_ready  out  1      buffer can accept a store
//   st_addr   in   32     store word address
//   st_data   in   WIDTH  store data
//   ld_addr   in   32     load word address to check for forwarding
//   ld_hit    out  1      a buffered store matches ld_addr
//   ld_data   out  WIDTH  data of the youngest matching store; 0 when ld_hit=0
//   mem_busy  in   1      memory port 0 is needed for a read this cycle
//   mem_we    out  1      write enable to memory port 0
//   mem_addr  out  32     head entry address to memory port 0
//   mem_din   out  WIDTH  head entry data to memory port 0
//   empty     out  1      no entries held
//   count     out  LOG2(DEPTH)+1  number of entries held
// BEHAVIOUR
//   Storage and pointers
//   - Circular array of DEPTH entries {addr, data}.
//   - Head and tail pointers are LOG2(DEPTH)+1 bits wide; the MSB is the wrap bit.
//   - full when the pointers differ only in the wrap bit; empty when they are equal.
//   Reset (rst=0, asynchronous)
//   - head=tail=0, so count=0, empty=1, st_ready=1, mem_we=0, ld_hit=0, ld_data=0.
//   - Entry contents are not reset.
//   - Any store or drain in flight is discarded; no memory write is issued
//     while rst=0.
//   Enqueue
//   - st_ready = !full, derived from registered state only.
//   - On posedge with st_valid && st_ready: write the entry at tail, tail += 1.
//   - The new entry is visible to forwarding and drain from the next cycle.
//   - When full, st_ready=0 even if a drain occurs in the same cycle
//     (no pass-through).
//   Drain
//   - mem_we = !empty && !mem_busy, combinational.
//   - mem_addr/mem_din always present the head entry; when empty they hold the
//     stale head entry and mem_we=0.
//   - On posedge with mem_we=1: head += 1. At most one drain per cycle;
//     strict FIFO order.
//   - Latency: a store accepted at edge N can be written at edge N+1 at the
//     earliest.
//   Simultaneous enqueue and drain
//   - Both pointers advance and count is unchanged.
//   - Legal at any count from 1 to DEPTH-1.
//   Forwarding (combinational)
//   - Compare ld_addr[AW-1:0] against addr[AW-1:0] of every valid entry.
//   - ld_hit=1 if any entry matches; ld_data = data of the youngest match
//     (closest to tail).
//   - The head entry being drained this cycle still forwards.
//   - A store presented on st_* in the same cycle is NOT forwarded; the
//     pipeline handles that case.
//   - Addresses differing only above bit AW-1 alias to the same word and
//     therefore match.
//   Arithmetic
//   - Pointers wrap modulo 2*DEPTH; count = tail - head, truncated to
//     LOG2(DEPTH)+1 bits.
// TESTING
//   1 Reset: 3 stores queued, mem_busy=1, drop rst to 0 mid-cycle
//     -> empty=1, count=0, mem_we=0, st_ready=1 immediately, before any clk edge.
//   2 Full: mem_busy=1, 4 stores (0x1..0x4) -> count=4, st_ready=0;
//     a 5th store held with st_valid=1 is not accepted and count stays 4.
//   3 Forward: stores {0x10,0xAAAA}, {0x10,0xBBBB}, mem_busy=1, ld_addr=0x10
//     -> ld_hit=1, ld_data=0xBBBB; ld_addr=0x11 -> ld_hit=0, ld_data=0.
//   4 Drain: from test 2 state, release mem_busy -> mem_we=1 on 4 consecutive
//     cycles with mem_addr 0x1,0x2,0x3,0x4 in order; then empty=1.
//     Memory read-back shows the data.
//   5 Concurrent: count=2, mem_busy=0, st_valid=1 every cycle for 5 cycles
//     -> count stays 2 and drained addresses are strictly in enqueue order.
//   6 Wrap/alias: 11 stores interleaved with drains so pointers wrap twice
//     -> order preserved; with AW=10, store at 0x010 and ld_addr=0x410
//     -> ld_hit=1.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order FIFO of pending stores placed directly in front of the write port
// (port 0) of a 2-read/1-write memory. The pipeline can retire a store in a
// single cycle even while the memory port is busy with a read. Entries drain
// to memory oldest-first, and loads that hit a buffered address get the data
// of the youngest matching store.
//
// Parameters
//   WIDTH  data word width (matches the memory word width)
//   DEPTH  number of entries, power of two, >= 2
//   AW     low address bits compared for forwarding (log2 of memory words)
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-low reset (0 = in reset)
//   st_valid  store request
//   st_ready  buffer can accept a store (not full)
//   st_addr   store word address
//   st_data   store data
//   ld_addr   load word address checked for forwarding
//   ld_hit    a buffered store matches ld_addr
//   ld_data   data of the youngest matching store, 0 when no hit
//   mem_busy  memory port 0 is needed for a read this cycle
//   mem_we    write enable to memory port 0
//   mem_addr  head entry address to memory port 0
//   mem_din   head entry data to memory port 0
//   empty     no entries held
//   count     number of entries held
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [WIDTH-1:0] st_data,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [WIDTH-1:0] ld_data,
    input  logic             mem_busy,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             empty,
    output logic [PW:0]      count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] head_q, head_d;
    logic [PW:0] tail_q, tail_d;

    // Entry storage; contents are deliberately left unreset.
    logic [31:0]      addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_idx;
    logic [PW-1:0] tail_idx;
    logic          full;
    logic          enq;

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    // -------------------------------------------------------------------------
    // Occupancy, derived from registered pointers only
    // -------------------------------------------------------------------------
    assign empty = (head_q == tail_q);
    assign full  = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);
    assign count = tail_q - head_q;

    // No pass-through: a full buffer refuses a store even if it drains now.
    assign st_ready = !full;
    assign enq      = st_valid && st_ready;

    // -------------------------------------------------------------------------
    // Drain port: the head entry is always presented, written when free
    // -------------------------------------------------------------------------
    assign mem_we   = !empty && !mem_busy;
    assign mem_addr = addr_mem[head_idx];
    assign mem_din  = data_mem[head_idx];

    // -------------------------------------------------------------------------
    // Pointer update
    // -------------------------------------------------------------------------
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (mem_we) begin
            head_d = head_q + 1'b1;
        end
        if (enq) begin
            tail_d = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_idx] <= st_addr;
            data_mem[tail_idx] <= st_data;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding
    // Entries are examined in age order starting at the head; slot k holds the
    // k-th oldest store and is live when k < count. The last live match in
    // age order is the youngest, so a simple overwrite loop picks it.
    // The head entry keeps forwarding in the cycle it drains because the
    // pointers only move at the clock edge.
    // -------------------------------------------------------------------------
    logic [PW-1:0] age_idx   [DEPTH];
    logic [DEPTH-1:0] age_live;
    logic [DEPTH-1:0] age_match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi]   = head_idx + PW'(gi);
            assign age_live[gi]  = ((PW + 1)'(gi) < count);
            assign age_match[gi] = age_live[gi] &&
                (addr_mem[age_idx[gi]][AW-1:0] == ld_addr[AW-1:0]);
        end
    endgenerate

    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_match[k]) begin
                ld_hit  = 1'b1;
                ld_data = data_mem[age_idx[k]];
            end
        end
    end

    // Upper load-address bits alias to the same word and are ignored.
    logic ld_addr_unused;
    assign ld_addr_unused = ^ld_addr[31:AW];

endmodule
